// File: rtl/buzz_pkg.sv
// Shared types and helpers for the quiz-buzzer arbiter.
package buzz_pkg;

  // Arbiter round states.
  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StAnswer
  } state_e;

  // Default number of contestants.
  localparam int unsigned DefaultNumPlayers = 4;

  // Round-robin successor of a player index. Callers guarantee n >= 2.
  function automatic int unsigned next_rr(input int unsigned id, input int unsigned n);
    return (id + 1) % n;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping
// around to bit 0.
module rr_pick #(
  parameter  int unsigned NUM_PLAYERS = 4,
  localparam int unsigned ID_W        = $clog2(NUM_PLAYERS)
) (
  input  logic [NUM_PLAYERS-1:0] req,
  input  logic [ID_W-1:0]        ptr,
  output logic                   any,
  output logic [ID_W-1:0]        idx
);

  int unsigned     cand;
  logic [ID_W-1:0] cand_idx;

  // Scan candidates ptr, ptr+1, ... (mod NUM_PLAYERS) and keep the first hit.
  always_comb begin
    any      = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < NUM_PLAYERS; k++) begin
      cand     = (32'(ptr) + k) % NUM_PLAYERS;
      cand_idx = ID_W'(cand);
      if (!any && req[cand_idx]) begin
        any = 1'b1;
        idx = cand_idx;
      end
    end
  end

endmodule

// File: rtl/buzzer_arbiter.sv
// Quiz-game buzzer arbiter: grants the answer turn to the first eligible press,
// times the answer window and applies the host's verdict.
module buzzer_arbiter
  import buzz_pkg::*;
#(
  parameter  int unsigned NUM_PLAYERS    = DefaultNumPlayers,
  parameter  int unsigned TIMEOUT_CYCLES = 50_000_000,
  localparam int unsigned ID_W           = $clog2(NUM_PLAYERS)
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [NUM_PLAYERS-1:0] press,
  input  logic                   arm,
  input  logic                   judge_valid,
  input  logic                   judge_correct,
  output logic                   winner_valid,
  output logic [ID_W-1:0]        winner_id,
  output logic [NUM_PLAYERS-1:0] locked_out,
  output logic                   armed,
  output logic                   timeout_pulse,
  output logic                   round_over
);

  localparam int unsigned        TIMER_W   = $clog2(TIMEOUT_CYCLES);
  // Window counts TIMEOUT_CYCLES-1 down to 0 inclusive, i.e. TIMEOUT_CYCLES cycles.
  localparam logic [TIMER_W-1:0] TimerLoad = TIMER_W'(TIMEOUT_CYCLES - 1);

  state_e                  state;
  logic [ID_W-1:0]         rr_ptr;
  logic [TIMER_W-1:0]      timer;

  logic [NUM_PLAYERS-1:0]  eligible;
  logic                    pick_any;
  logic [ID_W-1:0]         pick_idx;
  logic [NUM_PLAYERS-1:0]  lock_next;
  logic                    all_locked;

  // Only players not yet barred this round may win the turn.
  always_comb begin
    eligible = press & ~locked_out;
  end

  rr_pick #(
    .NUM_PLAYERS(NUM_PLAYERS)
  ) u_rr_pick (
    .req(eligible),
    .ptr(rr_ptr),
    .any(pick_any),
    .idx(pick_idx)
  );

  // Lockout set as it would be after barring the current holder.
  always_comb begin
    lock_next            = locked_out;
    lock_next[winner_id] = 1'b1;
    all_locked           = &lock_next;
  end

  // Round FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state         <= StIdle;
      rr_ptr        <= '0;
      timer         <= '0;
      winner_valid  <= 1'b0;
      winner_id     <= '0;
      locked_out    <= '0;
      armed         <= 1'b0;
      timeout_pulse <= 1'b0;
      round_over    <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      round_over    <= 1'b0;
      case (state)
        StIdle: begin
          if (arm) begin
            state      <= StArmed;
            armed      <= 1'b1;
            locked_out <= '0;
          end
        end
        StArmed: begin
          if (arm) begin
            // Restart: same-cycle presses are discarded.
            locked_out <= '0;
          end else if (pick_any) begin
            state        <= StAnswer;
            armed        <= 1'b0;
            winner_valid <= 1'b1;
            winner_id    <= pick_idx;
            timer        <= TimerLoad;
          end
        end
        StAnswer: begin
          if (judge_valid && judge_correct) begin
            state        <= StIdle;
            winner_valid <= 1'b0;
            winner_id    <= '0;
            round_over   <= 1'b1;
            rr_ptr       <= ID_W'(next_rr(32'(winner_id), NUM_PLAYERS));
          end else if (judge_valid || (timer == '0)) begin
            // A verdict on the expiry cycle takes precedence over the timeout.
            locked_out    <= lock_next;
            winner_valid  <= 1'b0;
            winner_id     <= '0;
            timeout_pulse <= !judge_valid;
            if (all_locked) begin
              state      <= StIdle;
              round_over <= 1'b1;
            end else begin
              state <= StArmed;
              armed <= 1'b1;
            end
          end else begin
            timer <= timer - TIMER_W'(1);
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
